// File: rtl/bpu_update_queue.sv
// Queues resolved-branch updates from the two execute pipes and presents them one per cycle,
// in program order, to the predictor's correct port.
`timescale 1ns/1ps
module bpu_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in0_valid_i,
    output logic                       in0_ready_o,
    input  logic [31:0]                in0_addr_i,
    input  logic                       in0_pht_flag_i,
    input  logic                       in0_bht_flag_i,
    input  logic                       in0_taken_i,
    input  logic                       in1_valid_i,
    output logic                       in1_ready_o,
    input  logic [31:0]                in1_addr_i,
    input  logic                       in1_pht_flag_i,
    input  logic                       in1_bht_flag_i,
    input  logic                       in1_taken_i,
    input  logic                       out_hold_i,
    output logic                       corr_valid_o,
    output logic [31:0]                corr_addr_o,
    output logic                       corr_pht_flag_o,
    output logic                       corr_bht_flag_o,
    output logic                       corr_taken_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_W-1:0]           sel_upd_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 35;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [ENT_W-1:0] ram [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, wr1_ptr;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;
    logic             push0, push1, pop;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] ent0, ent1;

    // Readiness looks only at the registered occupancy, so a pop this cycle never frees a slot early.
    assign in0_ready_o = (count_q < OCC_W'(DEPTH));
    assign in1_ready_o = (count_q <= OCC_W'(DEPTH - 2));
    assign push0       = in0_valid_i & in0_ready_o;
    assign push1       = in1_valid_i & in1_ready_o;

    assign head            = ram[rd_ptr_q];
    assign pop             = (count_q != '0) & ~out_hold_i;
    assign corr_valid_o    = pop;
    assign corr_addr_o     = head[34:3];
    assign corr_pht_flag_o = head[2];
    assign corr_bht_flag_o = head[1];
    assign corr_taken_o    = head[0];
    assign empty_o         = (count_q == '0);
    assign count_o         = count_q;
    assign sel_upd_cnt_o   = sel_cnt_q;

    assign ent0    = {in0_addr_i, in0_pht_flag_i, in0_bht_flag_i, in0_taken_i};
    assign ent1    = {in1_addr_i, in1_pht_flag_i, in1_bht_flag_i, in1_taken_i};
    // The younger pipe lands behind the older one when both fire, keeping program order.
    assign wr1_ptr = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + OCC_W'(push0) + OCC_W'(push1) - OCC_W'(pop);
        sel_cnt_d = sel_cnt_q;
        if (pop && (head[2] != head[1]))
            sel_cnt_d = sat_inc(sel_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sel_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sel_cnt_q <= sel_cnt_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push0)
            ram[wr_ptr_q] <= ent0;
        if (push1)
            ram[wr1_ptr] <= ent1;
    end

endmodule
